alu_step_sequencer: RTL

- Multi-cycle control-step FSM that sequences the 32-bit datapath around the ALU.
- Runs fetch (T0-T2), decodes IR[31:27] using the ALU's 5-bit opcode map, and issues per-step register-transfer strobes: ALU opcode, branch flag, and bus/register enables (T3-T7).
- Sits between the IR/CON flip-flop and the datapath.
- Stalls on memory steps until the memory handshake completes.

---
 rtl/alu_step_sequencer_if.sv | 35 +++
 rtl/alu_step_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_step_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_step_sequencer_if
// Description : Bundle between the step sequencer and the datapath.
//               Inputs to the sequencer: ir, con_ff, mem_ready.
//               Outputs from the sequencer: ctrl (strobe vector), alu_opcode,
//               alu_branch_flag, step (state code), run, mem_fault.
//               master = sequencer side, slave = datapath side.
// Revision    : 1.0  initial release
// ============================================================================
interface alu_step_sequencer_if #(
  parameter int OPW    = 5,
  parameter int CTRL_W = 28
);
  logic [31:0]       ir;
  logic              con_ff;
  logic              mem_ready;
  logic [CTRL_W-1:0] ctrl;
  logic [OPW-1:0]    alu_opcode;
  logic              alu_branch_flag;
  logic [3:0]        step;
  logic              run;
  logic              mem_fault;

  modport master (
    input  ir, con_ff, mem_ready,
    output ctrl, alu_opcode, alu_branch_flag, step, run, mem_fault
  );

  modport slave (
    output ir, con_ff, mem_ready,
    input  ctrl, alu_opcode, alu_branch_flag, step, run, mem_fault
  );
endinterface
`default_nettype wire

// File: rtl/alu_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_step_sequencer
// Description : Multi-cycle control-step FSM around the 32-bit ALU datapath.
//               Fetch in T0-T2, decode of ir[31:27], execute in T3-T7.
//               Moore outputs decoded from the state register and ir.
// Ports       : clk   - rising-edge clock
//               clear - asynchronous active-low reset
//               bus   - alu_step_sequencer_if.master (ir, con_ff, mem_ready in;
//                       ctrl, alu_opcode, alu_branch_flag, step, run,
//                       mem_fault out)
// Option      : SEQ_MEM_TIMEOUT_EN - bounds memory waits to MEM_TIMEOUT
//               stalled cycles, then HALT with sticky mem_fault.
// Revision    : 1.0  initial release
// ============================================================================
module alu_step_sequencer #(
  parameter int OPW         = 5,
  parameter int CTRL_W      = 28,
  parameter int MEM_TIMEOUT = 15
) (
  input  wire logic            clk,
  input  wire logic            clear,
  alu_step_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4    = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
  } state_t;

  // Opcode map (ir[31:27])
  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_ALU3_LAST = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_IMM_LAST  = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10001);
  localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10011);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(5'b10100);
  localparam logic [OPW-1:0] OP_IN   = OPW'(5'b10101);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(5'b10110);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(5'b10111);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(5'b11000);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11001);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11010);

  // Strobe masks
  localparam logic [CTRL_W-1:0] PC_OUT     = CTRL_W'(1 << 0);
  localparam logic [CTRL_W-1:0] PC_IN      = CTRL_W'(1 << 1);
  localparam logic [CTRL_W-1:0] INC_PC     = CTRL_W'(1 << 2);
  localparam logic [CTRL_W-1:0] MAR_IN     = CTRL_W'(1 << 3);
  localparam logic [CTRL_W-1:0] MDR_IN     = CTRL_W'(1 << 4);
  localparam logic [CTRL_W-1:0] MDR_OUT    = CTRL_W'(1 << 5);
  localparam logic [CTRL_W-1:0] MEM_READ   = CTRL_W'(1 << 6);
  localparam logic [CTRL_W-1:0] MEM_WRITE  = CTRL_W'(1 << 7);
  localparam logic [CTRL_W-1:0] IR_IN      = CTRL_W'(1 << 8);
  localparam logic [CTRL_W-1:0] Y_IN       = CTRL_W'(1 << 9);
  localparam logic [CTRL_W-1:0] Z_IN       = CTRL_W'(1 << 10);
  localparam logic [CTRL_W-1:0] ZLOW_OUT   = CTRL_W'(1 << 11);
  localparam logic [CTRL_W-1:0] ZHIGH_OUT  = CTRL_W'(1 << 12);
  localparam logic [CTRL_W-1:0] HI_IN      = CTRL_W'(1 << 13);
  localparam logic [CTRL_W-1:0] LO_IN      = CTRL_W'(1 << 14);
  localparam logic [CTRL_W-1:0] HI_OUT     = CTRL_W'(1 << 15);
  localparam logic [CTRL_W-1:0] LO_OUT     = CTRL_W'(1 << 16);
  localparam logic [CTRL_W-1:0] GRA        = CTRL_W'(1 << 17);
  localparam logic [CTRL_W-1:0] GRB        = CTRL_W'(1 << 18);
  localparam logic [CTRL_W-1:0] GRC        = CTRL_W'(1 << 19);
  localparam logic [CTRL_W-1:0] R_IN       = CTRL_W'(1 << 20);
  localparam logic [CTRL_W-1:0] R_OUT      = CTRL_W'(1 << 21);
  localparam logic [CTRL_W-1:0] BA_OUT     = CTRL_W'(1 << 22);
  localparam logic [CTRL_W-1:0] C_OUT      = CTRL_W'(1 << 23);
  localparam logic [CTRL_W-1:0] CON_IN     = CTRL_W'(1 << 24);
  localparam logic [CTRL_W-1:0] INPORT_OUT = CTRL_W'(1 << 25);
  localparam logic [CTRL_W-1:0] OUTPORT_IN = CTRL_W'(1 << 26);
  localparam logic [CTRL_W-1:0] LINK_IN    = CTRL_W'(1 << 27);

  state_t            state, next_state, last_step;
  logic [OPW-1:0]    op;
  logic              is_alu3, is_imm, is_muldiv, is_negnot, is_mem;
  logic              is_wait, stall, timeout;
  logic [CTRL_W-1:0] strobes;
  logic [OPW-1:0]    alu_op;
  logic              branch_flag;
  logic              unused_ir;

  assign op        = bus.ir[31 -: OPW];
  assign unused_ir = ^bus.ir[31-OPW:0];

  assign is_alu3   = (op >= OP_ADD) && (op <= OP_ALU3_LAST);
  assign is_imm    = (op > OP_ALU3_LAST) && (op <= OP_IMM_LAST);
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  assign is_negnot = (op == OP_NEG) || (op == OP_NOT);
  assign is_mem    = (op == OP_LD) || (op == OP_ST);

  // Only these steps look at mem_ready.
  assign is_wait = (state == S_T1) ||
                   ((state == S_T6) && (op == OP_LD)) ||
                   ((state == S_T7) && (op == OP_ST));
  assign stall   = is_wait && !bus.mem_ready;

`ifdef SEQ_MEM_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       fault;

  // wait_cnt is zero on entry to any wait step because the step before a
  // wait step never stalls; it counts stalled cycles already spent.
  assign timeout = stall && (wait_cnt == 4'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wait_cnt <= 4'd0;
      fault    <= 1'b0;
    end else begin
      wait_cnt <= stall ? wait_cnt + 4'd1 : 4'd0;
      if (timeout) fault <= 1'b1;
    end
  end

  assign bus.mem_fault = fault;
`else
  localparam int unused_timeout = MEM_TIMEOUT;
  assign timeout       = 1'b0;
  assign bus.mem_fault = 1'b0;
`endif

  // Final execute step of the current instruction.
  always_comb begin : last_step_decode
    last_step = S_T3;
    if (is_alu3 || is_imm || (op == OP_LDI))      last_step = S_T5;
    else if (is_muldiv || (op == OP_BR))          last_step = S_T6;
    else if (is_negnot || (op == OP_JAL))         last_step = S_T4;
    else if (is_mem)                              last_step = S_T7;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= S_RESET;
    else        state <= next_state;
  end

  always_comb begin : next_state_decode
    next_state = state;
    unique case (state)
      S_RESET: next_state = S_T0;
      S_HALT:  next_state = S_HALT;
      default: begin
        if (timeout)                                next_state = S_HALT;
        else if (stall)                             next_state = state;
        else if ((state == S_T3) && (op == OP_HALT)) next_state = S_HALT;
        else if ((state == last_step) || (state == S_T7)) next_state = S_T0;
        else                                        next_state = state_t'(state + 4'd1);
      end
    endcase
  end

  always_comb begin : output_decode
    strobes     = '0;
    alu_op      = OP_NOP;
    branch_flag = 1'b0;
    case (state)
      S_T0: strobes = PC_OUT | MAR_IN | INC_PC | Z_IN;
      S_T1: strobes = ZLOW_OUT | PC_IN | MEM_READ | MDR_IN;
      S_T2: strobes = MDR_OUT | IR_IN;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (is_alu3 || is_imm) begin
          case (state)
            S_T3: strobes = GRB | R_OUT | Y_IN;
            S_T4: begin
              strobes = (is_alu3 ? (GRC | R_OUT) : C_OUT) | Z_IN;
              alu_op  = op;
            end
            S_T5: strobes = ZLOW_OUT | GRA | R_IN;
            default: ;
          endcase
        end else if (is_muldiv) begin
          case (state)
            S_T3: strobes = GRA | R_OUT | Y_IN;
            S_T4: begin strobes = GRB | R_OUT | Z_IN; alu_op = op; end
            S_T5: strobes = ZLOW_OUT | LO_IN;
            S_T6: strobes = ZHIGH_OUT | HI_IN;
            default: ;
          endcase
        end else if (is_negnot) begin
          case (state)
            S_T3: begin strobes = GRB | R_OUT | Z_IN; alu_op = op; end
            S_T4: strobes = ZLOW_OUT | GRA | R_IN;
            default: ;
          endcase
        end else if (is_mem || (op == OP_LDI)) begin
          // ld/st share the ldi effective-address steps T3-T4.
          case (state)
            S_T3: strobes = GRB | BA_OUT | Y_IN;
            S_T4: begin strobes = C_OUT | Z_IN; alu_op = op; end
            S_T5: strobes = (op == OP_LDI) ? (ZLOW_OUT | GRA | R_IN) : (ZLOW_OUT | MAR_IN);
            S_T6: strobes = (op == OP_LD) ? (MEM_READ | MDR_IN) : (GRA | R_OUT | MDR_IN);
            S_T7: strobes = (op == OP_LD) ? (MDR_OUT | GRA | R_IN) : MEM_WRITE;
            default: ;
          endcase
        end else if (op == OP_BR) begin
          case (state)
            S_T3: strobes = GRA | R_OUT | CON_IN;
            S_T4: strobes = PC_OUT | Y_IN;
            S_T5: begin
              // Z = PC + C when taken, PC otherwise; ALU selects on the flag.
              strobes     = C_OUT | Z_IN;
              alu_op      = OP_BR;
              branch_flag = bus.con_ff;
            end
            S_T6: strobes = ZLOW_OUT | PC_IN;
            default: ;
          endcase
        end else if (op == OP_JAL) begin
          case (state)
            S_T3: strobes = PC_OUT | LINK_IN;
            S_T4: strobes = GRA | R_OUT | PC_IN;
            default: ;
          endcase
        end else if (state == S_T3) begin
          case (op)
            OP_JR:   strobes = GRA | R_OUT | PC_IN;
            OP_IN:   strobes = INPORT_OUT | GRA | R_IN;
            OP_OUT:  strobes = GRA | R_OUT | OUTPORT_IN;
            OP_MFHI: strobes = HI_OUT | GRA | R_IN;
            OP_MFLO: strobes = LO_OUT | GRA | R_IN;
            default: strobes = '0;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign bus.ctrl            = strobes;
  assign bus.alu_opcode      = alu_op;
  assign bus.alu_branch_flag = branch_flag;
  assign bus.step            = state;
  assign bus.run             = (state != S_RESET) && (state != S_HALT);

endmodule
`default_nettype wire
